// File: rtl/enemy_sprite_plotter_if.sv
// Plot request/acknowledge bundle between the enemy meta controller and the
// enemy sprite plotter.
//   should_plot   : request level, held by the controller until plot_finished
//   pose          : sprite pose to draw
//   base_x/base_y : sprite top-left screen position
//   plot_finished : acknowledge, plotter side
//   busy          : plotter is erasing, drawing or flushing
// Modports: master = meta controller, slave = plotter.
interface enemy_sprite_plotter_if #(
  parameter int unsigned POSE_W = 3,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7
);
  logic              should_plot;
  logic [POSE_W-1:0] pose;
  logic [X_W-1:0]    base_x;
  logic [Y_W-1:0]    base_y;
  logic              plot_finished;
  logic              busy;

  modport master (
    output should_plot, pose, base_x, base_y,
    input  plot_finished, busy
  );

  modport slave (
    input  should_plot, pose, base_x, base_y,
    output plot_finished, busy
  );
endinterface

// File: rtl/enemy_sprite_plotter.sv
// Enemy sprite plotter: on a plot request, erases the sprite at its previous
// position (if one was drawn), redraws the requested pose from the sprite ROM
// at the new position, then acknowledges with plot_finished (four-phase).
// Drives the shared VGA adapter pixel-write port. Off-screen pixels are
// clipped (no wrap); clipping never changes the cycle count.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   plot_if        : request/ack bundle (slave modport)
//   rom_addr       : {pose,row,col} sprite ROM address
//   rom_data       : ROM pixel, valid one cycle after rom_addr (registered ROM)
//   x, y, colour   : VGA pixel coordinate and colour
//   writeEn        : VGA pixel write strobe
// Build option: define ENEMY_PLOT_TRANSPARENCY_EN to skip writing DRAW pixels
// whose ROM colour equals TRANS_COLOUR.
module enemy_sprite_plotter #(
  parameter int unsigned COL_W    = 4,
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned POSE_W   = 3,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
`ifdef ENEMY_PLOT_TRANSPARENCY_EN
  , parameter logic [COLOUR_W-1:0] TRANS_COLOUR = COLOUR_W'(5)
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  enemy_sprite_plotter_if.slave           plot_if,
  output logic [POSE_W+ROW_W+COL_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0]             rom_data,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            writeEn
);

  localparam int unsigned CNT_W = ROW_W + COL_W;
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [POSE_W-1:0]           cur_pose_q, cur_pose_d;
  logic [X_W-1:0]              cur_x_q, cur_x_d, prev_x_q, prev_x_d;
  logic [Y_W-1:0]              cur_y_q, cur_y_d, prev_y_q, prev_y_d;
  logic                        prev_valid_q, prev_valid_d;
  logic [POSE_W+CNT_W-1:0]     rom_addr_q, rom_addr_d;
  // Draw pipeline stage: coordinates of the address issued last cycle
  logic                        pv_q, pv_d;
  logic                        pin_q, pin_d;
  logic [X_W-1:0]              px_q, px_d;
  logic [Y_W-1:0]              py_q, py_d;
  logic [X_W-1:0]              x_q, x_d;
  logic [Y_W-1:0]              y_q, y_d;
  logic [COLOUR_W-1:0]         colour_q, colour_d;
  logic                        we_q, we_d;
  logic                        pf_q, pf_d;
  logic                        busy_q, busy_d;

  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [X_W-1:0]              src_x;
  logic [Y_W-1:0]              src_y;
  logic [X_W:0]                sum_x;
  logic [Y_W:0]                sum_y;
  logic                        in_screen;

  assign col = cnt_q[COL_W-1:0];
  assign row = cnt_q[CNT_W-1:COL_W];

  // One extra bit on each sum so a carry past the screen edge clips
  // instead of wrapping to the left/top.
  always_comb begin
    src_x     = (state_q == S_ERASE) ? prev_x_q : cur_x_q;
    src_y     = (state_q == S_ERASE) ? prev_y_q : cur_y_q;
    sum_x     = {1'b0, src_x} + (X_W+1)'(col);
    sum_y     = {1'b0, src_y} + (Y_W+1)'(row);
    in_screen = (sum_x < SCR_W) && (sum_y < SCR_H);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_pose_d   = cur_pose_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    prev_x_d     = prev_x_q;
    prev_y_d     = prev_y_q;
    prev_valid_d = prev_valid_q;
    pv_d         = 1'b0;
    pin_d        = pin_q;
    px_d         = px_q;
    py_d         = py_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    we_d         = 1'b0;
    pf_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (plot_if.should_plot) begin
          cur_pose_d = plot_if.pose;
          cur_x_d    = plot_if.base_x;
          cur_y_d    = plot_if.base_y;
          cnt_d      = '0;
          state_d    = prev_valid_q ? S_ERASE : S_DRAW;
        end
      end
      S_ERASE: begin
        x_d      = sum_x[X_W-1:0];
        y_d      = sum_y[Y_W-1:0];
        colour_d = BG_COLOUR;
        we_d     = in_screen;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_DRAW;
      end
      S_DRAW: begin
        pv_d  = 1'b1;
        pin_d = in_screen;
        px_d  = sum_x[X_W-1:0];
        py_d  = sum_y[Y_W-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        prev_x_d     = cur_x_q;
        prev_y_d     = cur_y_q;
        prev_valid_d = 1'b1;
        state_d      = S_DONE;
      end
      S_DONE: begin
        // Hold the ack while the request is held; a request already dropped
        // still gets a one-cycle ack before returning to IDLE.
        pf_d = plot_if.should_plot || !pf_q;
        if (!plot_if.should_plot) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // rom_data now belongs to the address issued with the staged coordinates.
    if (pv_q) begin
      x_d      = px_q;
      y_d      = py_q;
      colour_d = rom_data;
`ifdef ENEMY_PLOT_TRANSPARENCY_EN
      we_d     = pin_q && (rom_data != TRANS_COLOUR);
`else
      we_d     = pin_q;
`endif
    end

    rom_addr_d = {cur_pose_d, cnt_d};
    busy_d     = (state_d == S_ERASE) || (state_d == S_DRAW) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_pose_q   <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      rom_addr_q   <= '0;
      pv_q         <= 1'b0;
      pin_q        <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      we_q         <= 1'b0;
      pf_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_pose_q   <= cur_pose_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      prev_x_q     <= prev_x_d;
      prev_y_q     <= prev_y_d;
      prev_valid_q <= prev_valid_d;
      rom_addr_q   <= rom_addr_d;
      pv_q         <= pv_d;
      pin_q        <= pin_d;
      px_q         <= px_d;
      py_q         <= py_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      we_q         <= we_d;
      pf_q         <= pf_d;
      busy_q       <= busy_d;
    end
  end

  assign rom_addr              = rom_addr_q;
  assign x                     = x_q;
  assign y                     = y_q;
  assign colour                = colour_q;
  assign writeEn               = we_q;
  assign plot_if.plot_finished = pf_q;
  assign plot_if.busy          = busy_q;

endmodule

// File: tb/tb_enemy_sprite_plotter.sv
module tb_enemy_sprite_plotter;

`ifdef ENEMY_PLOT_TRANSPARENCY_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] rom_addr;
  logic [2:0]  rom_data = '0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn;
  bit          trans_mode = 1'b0;

  enemy_sprite_plotter_if #(.POSE_W(3), .X_W(8), .Y_W(7)) pif();

  enemy_sprite_plotter dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .plot_if  (pif),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .writeEn  (writeEn)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Colours 0..4 normally; 5 (transparent key) on column 0 when trans_mode.
  function automatic logic [2:0] rom_fn(input logic [10:0] a, input bit tm);
    int s;
    if (tm && a[3:0] == 4'd0) return 3'd5;
    s = int'(a[3:0]) + int'(a[7:4]) + int'(a[10:8]);
    return 3'(s % 5);
  endfunction

  always @(posedge clock) rom_data <= rom_fn(rom_addr, trans_mode);

  logic [17:0] got[$];
  int first_wr = -1;
  always @(negedge clock) begin
    if (writeEn === 1'b1) begin
      if (got.size() == 0) first_wr = cyc;
      got.push_back({x, y, colour});
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  bit m_prev_valid = 1'b0;
  int m_prev_x = 0;
  int m_prev_y = 0;

  task automatic run_plot(input int pose, input int bx, input int by, input bit tm,
                          input int drop_at, input int exp_writes, input int exp_lat);
    logic [17:0] exp_q[$];
    int k, lat, mism, addr_cyc;
    bit seen, erase;
    logic [2:0] c;
    erase = m_prev_valid;
    if (erase)
      for (int r = 0; r < 16; r++)
        for (int cc = 0; cc < 16; cc++)
          if (m_prev_x + cc < 160 && m_prev_y + r < 120)
            exp_q.push_back({8'(m_prev_x + cc), 7'(m_prev_y + r), 3'd0});
    for (int r = 0; r < 16; r++)
      for (int cc = 0; cc < 16; cc++) begin
        c = rom_fn({3'(pose), 4'(r), 4'(cc)}, tm);
        if (bx + cc < 160 && by + r < 120 && !(TEN && c == 3'd5))
          exp_q.push_back({8'(bx + cc), 7'(by + r), c});
      end

    got.delete();
    first_wr = -1;
    trans_mode = tm;
    @(negedge clock);
    pif.pose = 3'(pose);
    pif.base_x = 8'(bx);
    pif.base_y = 7'(by);
    pif.should_plot = 1'b1;
    k = cyc + 1;
    addr_cyc = (erase ? k + 256 : k) + 5;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clock);
      if (drop_at > 0 && cyc == k + drop_at - 1) begin
        pif.should_plot = 1'b0;
        pif.base_x = 8'd0;
      end
      if (cyc == addr_cyc) chk("rom_addr", rom_addr, {3'(pose), 8'd5});
      if (pif.plot_finished === 1'b1) begin
        seen = 1'b1;
        lat = cyc - k;
      end
    end
    if (!seen) chk("finish_timeout", 0, 1);
    chk("finish_latency", lat, exp_lat);
    if (drop_at == 0) pif.should_plot = 1'b0;
    @(negedge clock);
    chk("finish_release", pif.plot_finished, 0);
    chk("busy_release", pif.busy, 0);
    chk("write_count", got.size(), exp_writes);
    mism = -1;
    if (got.size() == exp_q.size())
      foreach (exp_q[i]) if (mism < 0 && got[i] !== exp_q[i]) mism = i;
    chk("pixel_seq_first_bad_index", mism, -1);
    if (erase && m_prev_x < 160 && m_prev_y < 120)
      chk("first_erase_write", first_wr, k + 1);
    m_prev_valid = 1'b1;
    m_prev_x = bx;
    m_prev_y = by;
  endtask

  typedef struct {
    int pose;
    int bx;
    int by;
    bit tm;
    int drop_at;
    int exp_writes;
    int exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    vecs[0] = '{2,  10,  20, 1'b0, 0, 256, 258};
    vecs[1] = '{2,  30,  20, 1'b0, 0, 512, 514};
    vecs[2] = '{1, 150, 110, 1'b0, 0, 356, 514};
    vecs[3] = '{3,  40,  40, 1'b1, 0, TEN ? 340 : 356, 514};
    vecs[4] = '{5,  60,  50, 1'b0, 50, 512, 514};
    vecs[5] = '{7, 250,   5, 1'b0, 0, 256, 514};
    vecs[6] = '{0,   0,   0, 1'b0, 0, 256, 514};

    reset_n = 1'b0;
    pif.should_plot = 1'b0;
    pif.pose = '0;
    pif.base_x = '0;
    pif.base_y = '0;
    repeat (3) @(negedge clock);
    chk("reset_writeEn", writeEn, 0);
    chk("reset_xy", {x, y}, 0);
    chk("reset_colour", colour, 0);
    chk("reset_rom_addr", rom_addr, 0);
    chk("reset_finished", pif.plot_finished, 0);
    chk("reset_busy", pif.busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    foreach (vecs[i])
      run_plot(vecs[i].pose, vecs[i].bx, vecs[i].by, vecs[i].tm,
               vecs[i].drop_at, vecs[i].exp_writes, vecs[i].exp_lat);

    // Reset in the middle of DRAW (erase of previous sprite runs first).
    trans_mode = 1'b0;
    @(negedge clock);
    pif.pose = 3'd6;
    pif.base_x = 8'd20;
    pif.base_y = 7'd30;
    pif.should_plot = 1'b1;
    k = cyc + 1;
    while (cyc < k + 356) @(negedge clock);
    chk("busy_mid_draw", pif.busy, 1);
    chk("write_mid_draw", writeEn, 1);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_writeEn", writeEn, 0);
    chk("reset_mid_busy", pif.busy, 0);
    chk("reset_mid_finished", pif.plot_finished, 0);
    @(negedge clock);
    pif.should_plot = 1'b0;
    reset_n = 1'b1;
    m_prev_valid = 1'b0;
    repeat (2) @(negedge clock);
    run_plot(4, 5, 5, 1'b0, 0, 256, 258);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
